// File: rtl/prt_dp_lib_cdc_msg.sv
// Source-to-destination message CDC. A source FIFO feeds a holding register that is
// handed over with a two-phase req/ack toggle. The destination reset is derived internally.
`timescale 1ns/1ps
module prt_dp_lib_cdc_msg #(
   parameter int P_WIDTH  = 8,
   parameter int P_DEPTH  = 4,
   parameter int P_STAGES = 2
) (
   input  logic                       SRC_CLK_IN,
   input  logic                       prt_dp_lib_sclk_rst,
   input  logic [P_WIDTH-1:0]         SRC_DAT_IN,
   input  logic                       SRC_VLD_IN,
   output logic                       SRC_RDY_OUT,
   output logic [$clog2(P_DEPTH):0]   SRC_LVL_OUT,
   output logic                       SRC_BSY_OUT,
   input  logic                       DST_CLK_IN,
   output logic [P_WIDTH-1:0]         DST_DAT_OUT,
   output logic                       DST_VLD_OUT
);
   localparam int AW = $clog2(P_DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT} state_t;

   // ---------------- source domain ----------------
   logic [P_WIDTH-1:0]  r_mem [P_DEPTH];
   logic [AW-1:0]       r_wptr, r_rptr;
   logic [LW-1:0]       r_lvl, w_lvl_nxt;
   logic                r_rdy, r_bsy, r_req;
   logic [P_WIDTH-1:0]  r_hold;
   logic [P_STAGES-1:0] r_ack_sync, r_alive_sync;
   state_t              r_state, w_state_nxt;
   logic                w_push, w_pop;

   // ---------------- destination domain ----------------
   logic [P_STAGES-1:0] r_drst_chain;
   logic [P_STAGES-1:0] r_req_sync;
   logic                w_drst, r_alive, r_req_prev, r_ack, w_req_edge;
   logic [P_WIDTH-1:0]  r_dat;
   logic                r_vld;

   assign w_push = SRC_VLD_IN & r_rdy;

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         S_INIT: if (r_alive_sync[P_STAGES-1]) w_state_nxt = S_IDLE;
         S_IDLE: if (r_lvl != '0) begin
            w_pop       = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: if (r_ack_sync[P_STAGES-1] == r_req) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_INIT;
      endcase
   end

   always_comb begin
      w_lvl_nxt = r_lvl;
      case ({w_push, w_pop})
         2'b10:   w_lvl_nxt = r_lvl + 1'b1;
         2'b01:   w_lvl_nxt = r_lvl - 1'b1;
         default: w_lvl_nxt = r_lvl;
      endcase
   end

   always_ff @(posedge SRC_CLK_IN) begin
      if (w_push) r_mem[r_wptr] <= SRC_DAT_IN;
   end

   always_ff @(posedge SRC_CLK_IN or posedge prt_dp_lib_sclk_rst) begin
      if (prt_dp_lib_sclk_rst) begin
         r_state      <= S_INIT;
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_lvl        <= '0;
         r_rdy        <= 1'b0;
         r_bsy        <= 1'b0;
         r_req        <= 1'b0;
         r_hold       <= '0;
         r_ack_sync   <= '0;
         r_alive_sync <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_lvl        <= w_lvl_nxt;
         r_ack_sync   <= {r_ack_sync[P_STAGES-2:0], r_ack};
         r_alive_sync <= {r_alive_sync[P_STAGES-2:0], r_alive};
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
            r_hold <= r_mem[r_rptr];
            r_req  <= ~r_req;
         end
         r_rdy <= (w_state_nxt != S_INIT) && (w_lvl_nxt != LW'(P_DEPTH));
         r_bsy <= (w_lvl_nxt != '0) || (w_state_nxt == S_WAIT);
      end
   end

   assign SRC_RDY_OUT = r_rdy;
   assign SRC_LVL_OUT = r_lvl;
   assign SRC_BSY_OUT = r_bsy;

   // Destination reset asserts with the source reset and releases after P_STAGES dst edges
   always_ff @(posedge DST_CLK_IN or posedge prt_dp_lib_sclk_rst) begin
      if (prt_dp_lib_sclk_rst) r_drst_chain <= '1;
      else                     r_drst_chain <= {r_drst_chain[P_STAGES-2:0], 1'b0};
   end
   assign w_drst = r_drst_chain[P_STAGES-1];

   assign w_req_edge = r_req_sync[P_STAGES-1] ^ r_req_prev;

   // r_hold is stable while req is in flight, so it is sampled here without a synchroniser
   always_ff @(posedge DST_CLK_IN or posedge w_drst) begin
      if (w_drst) begin
         r_alive    <= 1'b0;
         r_req_sync <= '0;
         r_req_prev <= 1'b0;
         r_ack      <= 1'b0;
         r_dat      <= '0;
         r_vld      <= 1'b0;
      end else begin
         r_alive    <= 1'b1;
         r_req_sync <= {r_req_sync[P_STAGES-2:0], r_req};
         r_req_prev <= r_req_sync[P_STAGES-1];
         r_vld      <= w_req_edge;
         if (w_req_edge) begin
            r_dat <= r_hold;
            r_ack <= r_req_sync[P_STAGES-1];
         end
      end
   end

   assign DST_DAT_OUT = r_dat;
   assign DST_VLD_OUT = r_vld;

endmodule

// File: tb/tb_prt_dp_lib_cdc_msg.sv
// Randomised bench for prt_dp_lib_cdc_msg: a word queue models the in-order channel,
// with occupancy/busy/hold/strobe properties checked against it.
`timescale 1ns/1ps
module tb_prt_dp_lib_cdc_msg;
   localparam int W = 8;
   localparam int D = 4;
   localparam int S = 2;

   logic              src_clk = 1'b0, dst_clk = 1'b0, rst = 1'b1;
   logic [W-1:0]      src_dat = '0;
   logic              src_vld = 1'b0;
   logic              rdy, bsy, dst_vld;
   logic [$clog2(D):0] lvl;
   logic [W-1:0]      dst_dat;

   realtime src_half = 5.0, dst_half = 5.0;
   bit      dst_run  = 1'b1;

   int checks = 0, errors = 0;
   logic [W-1:0] q[$];
   logic [W-1:0] last_dat = '0;
   bit  prev_vld = 1'b0, mon_en = 1'b0, seen_full = 1'b0;
   int  n_deliv = 0, base = 0;
   int  m_out, m_lvl, m_exp;

   prt_dp_lib_cdc_msg #(.P_WIDTH(W), .P_DEPTH(D), .P_STAGES(S)) dut (
      .SRC_CLK_IN(src_clk), .prt_dp_lib_sclk_rst(rst), .SRC_DAT_IN(src_dat),
      .SRC_VLD_IN(src_vld), .SRC_RDY_OUT(rdy), .SRC_LVL_OUT(lvl), .SRC_BSY_OUT(bsy),
      .DST_CLK_IN(dst_clk), .DST_DAT_OUT(dst_dat), .DST_VLD_OUT(dst_vld)
   );

   always begin #(src_half); src_clk = ~src_clk; end
   always begin #(dst_half); if (dst_run) dst_clk = ~dst_clk; end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Accepted words enter the model queue
   always @(posedge src_clk) if (!rst && src_vld && rdy) q.push_back(src_dat);

   // Occupancy: undelivered words are either in the FIFO or the one in flight
   always @(negedge src_clk) if (mon_en) begin
      m_out = q.size();
      m_lvl = int'(lvl);
      m_exp = m_lvl;
      if (m_lvl > m_out)          m_exp = m_out;
      else if (m_lvl + 1 < m_out) m_exp = m_out - 1;
      chk("lvl_vs_model", lvl, m_exp);
      if (m_lvl >= D) begin
         seen_full = 1'b1;
         chk("rdy_when_full", rdy, 0);
      end
      if (m_out > 0) chk("bsy_pending", bsy, 1);
   end

   always @(posedge dst_clk) begin
      #1;
      if (dst_vld) begin
         if (prev_vld) chk("dst_double", dst_vld, 0);
         if (q.size() == 0) chk("dst_unexpected", dst_vld, 0);
         else begin
            last_dat = q.pop_front();
            chk("dst_dat", dst_dat, last_dat);
            n_deliv++;
         end
      end else chk("dst_hold", dst_dat, last_dat);
      prev_vld = dst_vld;
   end

   task automatic send(input logic [W-1:0] w);
      int n = 0;
      @(negedge src_clk);
      src_dat = w;
      src_vld = 1'b1;
      do begin @(posedge src_clk); n++; end while (!rdy && n < 200);
      if (n >= 200) chk("send_timeout", rdy, 1);
   endtask

   task automatic idle();
      @(negedge src_clk);
      src_vld = 1'b0;
   endtask

   task automatic wait_rdy(input string tag);
      int n = 0;
      while (rdy !== 1'b1 && n < 100) begin @(negedge src_clk); n++; end
      chk(tag, rdy, 1);
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((q.size() != 0 || bsy !== 1'b0) && n < 20000) begin @(negedge src_clk); n++; end
      chk({tag, "_q"}, q.size(), 0);
      chk({tag, "_bsy"}, bsy, 0);
   endtask

   task automatic assert_rst();
      mon_en   = 1'b0;
      src_vld  = 1'b0;
      rst      = 1'b1;
      q.delete();
      last_dat = '0;
      prev_vld = 1'b0;
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state and init sequence at equal clocks
      #22;
      chk("rst_rdy", rdy, 0);
      chk("rst_lvl", lvl, 0);
      chk("rst_bsy", bsy, 0);
      chk("rst_dvld", dst_vld, 0);
      chk("rst_ddat", dst_dat, 0);
      @(negedge src_clk) rst = 1'b0;
      mon_en = 1'b1;
      repeat (S + 2) begin @(negedge src_clk); chk("init_rdy_low", rdy, 0); end
      wait_rdy("init_rdy_up");
      chk("init_lvl", lvl, 0);

      // single word
      base = n_deliv;
      send(8'hA5); idle();
      wait_drain("t2");
      chk("t2_cnt", n_deliv - base, 1);
      chk("t2_hold", dst_dat, 8'hA5);

      // burst into slow destination
      src_half = 2.5; dst_half = 20.0;
      base = n_deliv; seen_full = 1'b0;
      for (int i = 1; i <= 16; i++) send(W'(i));
      idle();
      wait_drain("t3");
      chk("t3_cnt", n_deliv - base, 16);
      chk("t3_full_seen", seen_full, 1);
      chk("t3_last", dst_dat, 8'h10);

      // fast destination, random words and gaps
      src_half = 20.0; dst_half = 2.5;
      base = n_deliv;
      for (int i = 0; i < 400; i++) begin
         int gap;
         send(W'($urandom));
         gap = $urandom_range(0, 3);
         if (gap > 0) begin
            idle();
            repeat (gap - 1) @(negedge src_clk);
         end
      end
      idle();
      wait_drain("t4");
      chk("t4_cnt", n_deliv - base, 400);

      // equal clocks, pointer wrap with back-to-back traffic
      src_half = 5.0; dst_half = 5.0;
      base = n_deliv;
      for (int i = 0; i < 3 * D + 1; i++) send(W'(8'h40 + i));
      idle();
      wait_drain("t5");
      chk("t5_cnt", n_deliv - base, 3 * D + 1);

      // reset while waiting with three words queued, destination clock stopped
      dst_run = 1'b0;
      for (int i = 0; i < 4; i++) send(W'(8'h90 + i));
      idle();
      repeat (4) @(negedge src_clk);
      chk("t6_lvl", lvl, 3);
      chk("t6_bsy", bsy, 1);
      assert_rst();
      #1;
      chk("t6_rst_rdy", rdy, 0);
      chk("t6_rst_lvl", lvl, 0);
      chk("t6_rst_bsy", bsy, 0);
      chk("t6_rst_dvld", dst_vld, 0);
      chk("t6_rst_ddat", dst_dat, 0);
      dst_run = 1'b1;
      repeat (3) @(negedge src_clk);
      rst = 1'b0;
      mon_en = 1'b1;
      base = n_deliv;
      @(negedge src_clk);
      chk("t6_init_rdy_low", rdy, 0);
      wait_rdy("t6_rdy_up");
      send(8'h3C); idle();
      wait_drain("t6");
      chk("t6_cnt", n_deliv - base, 1);
      chk("t6_dat", dst_dat, 8'h3C);

      repeat (4) @(negedge src_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
